// File: rtl/dfd_cla_node_sequencer_if.sv
// dfd_cla_node_sequencer_if: CSR control/status and EAP-set signals of the CLA node sequencer.
// node_history exists only when CLA_NODE_SEQ_HISTORY_EN is defined.
interface dfd_cla_node_sequencer_if #(
    parameter int NUM_NODES = 4,
    parameter int NODE_ID_W = $clog2(NUM_NODES),
    parameter int NUM_EAPS  = 4,
    parameter int TIMEOUT_W = 16,
    parameter int XCNT_W    = 16
);
    logic                 cla_enable;
    logic                 cla_start;
    logic                 cla_stop;
    logic [NODE_ID_W-1:0] start_node_id;
    logic [NUM_EAPS-1:0]  eap_hit;
    logic [NODE_ID_W-1:0] next_destination_node_id;
    logic [TIMEOUT_W-1:0] timeout_limit;
    logic [NODE_ID_W-1:0] timeout_dest_node_id;
    logic                 err_clear;
    logic [NODE_ID_W-1:0] current_node_id;
    logic                 enable_eap;
    logic [1:0]           seq_state;
    logic                 node_transition;
    logic                 timeout_pulse;
    logic [XCNT_W-1:0]    transition_count;
    logic                 node_id_err;
`ifdef CLA_NODE_SEQ_HISTORY_EN
    logic [4*NODE_ID_W-1:0] node_history;
`endif

    modport master (
        output cla_enable, cla_start, cla_stop, start_node_id, eap_hit,
               next_destination_node_id, timeout_limit, timeout_dest_node_id, err_clear,
        input
`ifdef CLA_NODE_SEQ_HISTORY_EN
              node_history,
`endif
              current_node_id, enable_eap, seq_state, node_transition, timeout_pulse,
              transition_count, node_id_err
    );

    modport slave (
        input  cla_enable, cla_start, cla_stop, start_node_id, eap_hit,
               next_destination_node_id, timeout_limit, timeout_dest_node_id, err_clear,
        output
`ifdef CLA_NODE_SEQ_HISTORY_EN
               node_history,
`endif
               current_node_id, enable_eap, seq_state, node_transition, timeout_pulse,
               transition_count, node_id_err
    );
endinterface

// File: rtl/dfd_cla_node_sequencer.sv
// dfd_cla_node_sequencer: CLA node state machine owning current_node_id and gating enable_eap.
// Define CLA_NODE_SEQ_HISTORY_EN to add the node_history shift register output.
module dfd_cla_node_sequencer #(
    parameter int NUM_NODES = 4,
    parameter int NODE_ID_W = $clog2(NUM_NODES),
    parameter int NUM_EAPS  = 4,
    parameter int TIMEOUT_W = 16,
    parameter int XCNT_W    = 16
) (
    input logic                     clock,
    input logic                     reset,
    dfd_cla_node_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, HALT} state_t;

    state_t               state, state_nx;
    logic [NODE_ID_W-1:0] node, node_nx;
    logic [TIMEOUT_W-1:0] dwell, dwell_nx;
    logic [XCNT_W-1:0]    cnt, cnt_nx;
    logic [NUM_EAPS-1:0]  hits;
    logic                 err, err_nx, en_eap, xt, tp;
    logic                 hit, run, arm, dest_ok, tdest_ok, start_ok, tmo, move_hit, move_tmo;

    function automatic logic in_range(input logic [NODE_ID_W-1:0] id);
        return 32'(id) < NUM_NODES;
    endfunction

    assign hits = bus.eap_hit;

    always_comb begin
        hit      = |hits;
        dest_ok  = in_range(bus.next_destination_node_id);
        tdest_ok = in_range(bus.timeout_dest_node_id);
        start_ok = in_range(bus.start_node_id);
        run      = bus.cla_enable && state == RUN;
        arm      = bus.cla_enable && state == IDLE && bus.cla_start;
        // Any hit, even one with a bad destination, suppresses the timeout.
        tmo      = run && !hit && bus.timeout_limit != '0 &&
                   dwell == TIMEOUT_W'(bus.timeout_limit - 1'b1);
        move_hit = run && hit && dest_ok && bus.next_destination_node_id != node;
        move_tmo = tmo && tdest_ok;
        state_nx = !bus.cla_enable ? IDLE :
                   state == IDLE   ? (bus.cla_start ? ARM : IDLE) :
                   state == ARM    ? RUN :
                   state == RUN    ? (bus.cla_stop ? HALT : RUN) :
                   (bus.cla_start && !bus.cla_stop ? RUN : HALT);
        node_nx  = !bus.cla_enable ? '0 :
                   arm      ? (start_ok ? bus.start_node_id : '0) :
                   move_hit ? bus.next_destination_node_id :
                   move_tmo ? bus.timeout_dest_node_id : node;
        dwell_nx = (!bus.cla_enable || state == IDLE || (run && hit && dest_ok) || tmo) ? '0 :
                   (!run || &dwell) ? dwell : dwell + 1'b1;
        cnt_nx   = arm ? '0 : ((move_hit || move_tmo) && !(&cnt)) ? cnt + 1'b1 : cnt;
        err_nx   = (arm && !start_ok) || (run && hit && !dest_ok) || (tmo && !tdest_ok) ||
                   (err && !bus.err_clear);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            node   <= '0;
            dwell  <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            en_eap <= 1'b0;
            xt     <= 1'b0;
            tp     <= 1'b0;
        end else begin
            state  <= state_nx;
            node   <= node_nx;
            dwell  <= dwell_nx;
            cnt    <= cnt_nx;
            err    <= err_nx;
            en_eap <= state_nx == RUN;
            xt     <= move_hit || move_tmo;
            tp     <= move_tmo;
        end
    end

    assign bus.current_node_id  = node;
    assign bus.enable_eap       = en_eap;
    assign bus.seq_state        = state;
    assign bus.node_transition  = xt;
    assign bus.timeout_pulse    = tp;
    assign bus.transition_count = cnt;
    assign bus.node_id_err      = err;

`ifdef CLA_NODE_SEQ_HISTORY_EN
    logic [4*NODE_ID_W-1:0] hist;

    // Pushed at the commit edge so the new entry is visible with node_transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) hist <= '0;
        else if (arm) hist <= '0;
        else if (move_hit || move_tmo) hist <= {hist[3*NODE_ID_W-1:0], node};
    end

    assign bus.node_history = hist;
`endif
endmodule

// File: tb/tb_dfd_cla_node_sequencer.sv
// tb_dfd_cla_node_sequencer: directed and random stimulus against a behavioural sequencer model.
// Uses a 3-bit node ID with 4 nodes so out-of-range destinations are reachable.
module tb_dfd_cla_node_sequencer;
    localparam int NN = 4, IW = 3, NE = 4, TW = 4, XW = 4;
    localparam int IDLE = 0, ARM = 1, RUN = 2, HALT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_state, m_node, m_dwell, m_cnt;
    bit   m_err, m_xt, m_tp;
    int   m_hist[$];

    dfd_cla_node_sequencer_if #(.NUM_NODES(NN), .NODE_ID_W(IW), .NUM_EAPS(NE),
                                .TIMEOUT_W(TW), .XCNT_W(XW)) bus ();
    dfd_cla_node_sequencer #(.NUM_NODES(NN), .NODE_ID_W(IW), .NUM_EAPS(NE),
                             .TIMEOUT_W(TW), .XCNT_W(XW)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input bit st, input bit sp, input int sid, input int hit,
                         input int dst, input int lim, input int tdst, input bit clr);
        bus.cla_enable               = en;
        bus.cla_start                = st;
        bus.cla_stop                 = sp;
        bus.start_node_id            = IW'(sid);
        bus.eap_hit                  = NE'(hit);
        bus.next_destination_node_id = IW'(dst);
        bus.timeout_limit            = TW'(lim);
        bus.timeout_dest_node_id     = IW'(tdst);
        bus.err_clear                = clr;
    endtask

    task automatic model_reset();
        m_state = IDLE; m_node = 0; m_dwell = 0; m_cnt = 0;
        m_err = 0; m_xt = 0; m_tp = 0;
        m_hist.delete();
    endtask

    function automatic int sat_inc(input int v, input int w);
        return (v == (1 << w) - 1) ? v : v + 1;
    endfunction

    // Next-cycle behaviour from the current model state and the inputs now on the bus.
    task automatic model_step();
        int  ns = m_state, nnode = m_node, nd = m_dwell, nc = m_cnt;
        int  dst = int'(bus.next_destination_node_id), tdst = int'(bus.timeout_dest_node_id);
        int  lim = int'(bus.timeout_limit), sid = int'(bus.start_node_id);
        bit  h = bus.eap_hit != 0, ferr = 0, moved = 0, tmo = 0;
        if (!bus.cla_enable) begin
            ns = IDLE; nnode = 0; nd = 0;
        end else if (m_state == IDLE) begin
            if (bus.cla_start) begin
                ns = ARM; nc = 0; nd = 0; m_hist.delete();
                if (sid < NN) nnode = sid;
                else begin nnode = 0; ferr = 1; end
            end
        end else if (m_state == ARM) begin
            ns = RUN;
        end else if (m_state == RUN) begin
            if (h) begin
                if (dst >= NN) begin ferr = 1; nd = sat_inc(m_dwell, TW); end
                else begin
                    nd = 0;
                    if (dst != m_node) begin nnode = dst; moved = 1; end
                end
            end else if (lim != 0 && m_dwell == lim - 1) begin
                nd = 0;
                if (tdst >= NN) ferr = 1;
                else begin nnode = tdst; moved = 1; tmo = 1; end
            end else nd = sat_inc(m_dwell, TW);
            if (bus.cla_stop) ns = HALT;
        end else if (bus.cla_start && !bus.cla_stop) begin
            ns = RUN;
        end
        if (moved) begin
            nc = sat_inc(nc, XW);
            m_hist.push_front(m_node);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
        end
        m_err   = ferr || (m_err && !bus.err_clear);
        m_state = ns; m_node = nnode; m_dwell = nd; m_cnt = nc;
        m_xt    = moved; m_tp = tmo;
    endtask

    task automatic compare_all();
        check("node", bus.current_node_id, m_node);
        check("state", bus.seq_state, m_state);
        check("enable_eap", bus.enable_eap, m_state == RUN);
        check("node_transition", bus.node_transition, m_xt);
        check("timeout_pulse", bus.timeout_pulse, m_tp);
        check("count", bus.transition_count, m_cnt);
        check("node_id_err", bus.node_id_err, m_err);
`ifdef CLA_NODE_SEQ_HISTORY_EN
        begin
            int e = 0;
            foreach (m_hist[i]) e |= m_hist[i] << (i * IW);
            check("history", bus.node_history, e);
        end
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        compare_all();
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        cyc();
        check("arm_state", bus.seq_state, ARM);
        check("arm_enable_eap", bus.enable_eap, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc();
        check("run_enable_eap", bus.enable_eap, 1);
        check("run_start_node", bus.current_node_id, 1);
        drive(1, 0, 0, 0, 4'b0100, 3, 5, 0, 0);
        cyc();
        check("hit_node", bus.current_node_id, 3);
        check("hit_pulse", bus.node_transition, 1);
        check("hit_count", bus.transition_count, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 5, 0, 0);
            cyc();
            check("tmo_pulse", bus.timeout_pulse, i == 4);
            check("tmo_node", bus.current_node_id, i == 4 ? 0 : 3);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, i == 4 ? 4'b0001 : 0, 2, 5, 0, 0);
            cyc();
            check("hit_vs_tmo_pulse", bus.timeout_pulse, 0);
            check("hit_vs_tmo_node", bus.current_node_id, i == 4 ? 2 : 0);
        end
        drive(1, 0, 0, 0, 4'b1000, 5, 0, 0, 0);
        cyc();
        check("bad_dest_node", bus.current_node_id, 2);
        check("bad_dest_err", bus.node_id_err, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        check("err_sticky", bus.node_id_err, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        check("err_cleared", bus.node_id_err, 0);
        drive(1, 0, 0, 0, 4'b0010, 5, 0, 0, 1);
        cyc();
        check("err_clear_vs_new", bus.node_id_err, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc();
        check("stop_state", bus.seq_state, HALT);
        check("stop_enable_eap", bus.enable_eap, 0);
        check("stop_node", bus.current_node_id, 2);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc();
        check("start_stop_halt", bus.seq_state, HALT);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        check("resume_state", bus.seq_state, RUN);
        check("resume_node", bus.current_node_id, 2);
        check("resume_count", bus.transition_count, 3);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_state", bus.seq_state, IDLE);
        compare_all();
        #1 reset = 1'b0;
        repeat (3000) begin
            drive($urandom_range(0, 40) != 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 12) == 0, $urandom_range(0, 5),
                  $urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : 0,
                  $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 5),
                  $urandom_range(0, 9) == 0);
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dfd_cla_node_sequencer.md
Name: dfd_cla_node_sequencer

Overview:
- Sequences the CLA node state machine: owns current_node_id and gates enable_eap into the node EAP set.
- Advances to the EAP-selected destination node on a hit, or to a programmed node on a dwell timeout.
- Provides start/stop/halt control, a transition counter and sticky error status for CSR readback.
- Sits between the CLA CSR block and the node EAP set.

Parameters:
- NUM_NODES, 4, number of CLA nodes.
- NODE_ID_W, $clog2(NUM_NODES), node ID width.
- NUM_EAPS, 4, EAPs per node.
- TIMEOUT_W, 16, dwell counter and timeout limit width.
- XCNT_W, 16, transition counter width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- cla_enable  in  1  level; global CLA enable.
- cla_start  in  1  pulse; start from IDLE or resume from HALT.
- cla_stop  in  1  pulse; RUN to HALT.
- start_node_id  in  NODE_ID_W  node loaded on start from IDLE.
- eap_hit  in  NUM_EAPS  per-EAP logic result (snapshot_capture_per_eap).
- next_destination_node_id  in  NODE_ID_W  EAP-set priority-resolved destination.
- timeout_limit  in  TIMEOUT_W  dwell cycles before a forced move; 0 disables.
- timeout_dest_node_id  in  NODE_ID_W  target on timeout.
- err_clear  in  1  W2C pulse; clears node_id_err.
- current_node_id  out  NODE_ID_W  active node.
- enable_eap  out  1  EAP evaluation enable.
- seq_state  out  2  0=IDLE, 1=ARM, 2=RUN, 3=HALT.
- node_transition  out  1  one-cycle pulse on a node change.
- timeout_pulse  out  1  one-cycle pulse on a timeout-forced change.
- transition_count  out  XCNT_W  saturating count of node changes.
- node_id_err  out  1  sticky flag: out-of-range destination seen.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0.
- IDLE: enable_eap=0; current_node_id=0; dwell=0.
  - cla_start & cla_enable -> ARM.
  - On entry to ARM: transition_count cleared, current_node_id <= start_node_id.
  - If start_node_id >= NUM_NODES: load 0 instead and set node_id_err.
- ARM: exactly one cycle; enable_eap=0 so EAP counters see a clean boundary. Goes to RUN next cycle.
- RUN: enable_eap=1; dwell increments each cycle, saturating at all-ones.
  - hit = |eap_hit. Hit in cycle N with dest != current_node_id and dest < NUM_NODES:
    - current_node_id updates at the end of N.
    - node_transition=1 in N+1.
    - dwell <= 0.
    - transition_count += 1, saturating.
  - Hit with dest == current: self-loop; no pulse, no count. dwell <= 0.
  - Hit with dest >= NUM_NODES: ignored; node_id_err set; dwell continues.
  - Timeout: no hit, timeout_limit != 0 and dwell == timeout_limit-1 in cycle N:
    - Move to timeout_dest_node_id with the same timing as a hit transition.
    - timeout_pulse and node_transition both 1 in N+1; transition_count += 1.
    - If timeout_dest == current: pulses and count still occur; dwell <= 0.
    - If timeout_dest is out of range: node_id_err set, no move, dwell <= 0.
  - Hit and timeout in the same cycle: hit wins; no timeout_pulse.
  - cla_stop -> HALT. Stop in the same cycle as a hit: the transition still commits, then HALT.
- HALT: enable_eap=0; current_node_id, dwell and count held.
  - cla_start -> RUN (resume, no ARM).
  - Start and stop in the same cycle in HALT: stay in HALT.
- cla_enable=0 in any state -> IDLE next cycle; current_node_id <= 0; dwell <= 0; transition_count held.
- node_id_err: err_clear and a new error in the same cycle leaves it set.
- enable_eap is registered and equals (next state == RUN) as a flop output.

Optional Feature:
- Macro: CLA_NODE_SEQ_HISTORY_EN.
- Defined: adds output node_history [4*NODE_ID_W].
  - A shift register of the previous current_node_id values, pushed on every node_transition; newest in bits [NODE_ID_W-1:0].
  - Cleared on reset and on IDLE->ARM.
- Undefined: no port and no history logic.

Test Plan:
- Reset asserted mid-RUN at node 2 -> all outputs 0 immediately (asynchronously); seq_state=IDLE.
- Start with start_node_id=1 -> ARM for 1 cycle with enable_eap=0, then RUN with enable_eap=1 and current_node_id=1.
- In RUN at node 1: eap_hit=4'b0100, dest=3 -> current_node_id=3 and node_transition=1 the next cycle; transition_count=1.
- timeout_limit=5, timeout_dest=0, no hits from node 3 -> the move to node 0 appears with timeout_pulse=1 five cycles after dwell reset.
  - Repeat with a hit on the fifth cycle -> hit destination taken, timeout_pulse=0.
- dest=5 with NUM_NODES=4 -> no move; node_id_err=1 until err_clear; err_clear concurrent with a new error -> node_id_err stays 1.
- cla_stop in RUN -> HALT with enable_eap=0 and node held.
  - Start+stop together in HALT -> remains HALT.
  - cla_start alone -> RUN at the same node with transition_count unchanged.
